// File: rtl/exp_job_scheduler.sv
// Round-robin front end sharing one a^n exponent engine between two requesters.
// Optional feature macro: LCD_MIRROR_EN (forward each good result to the LCD first).
module exp_job_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CW             = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [7:0]  a0_i,
  input  logic [7:0]  n0_i,
  input  logic [7:0]  a1_i,
  input  logic [7:0]  n1_i,
  output logic [1:0]  ack_o,
  output logic [1:0]  valid_o,
  output logic        err_o,
  output logic [15:0] result_o,
  output logic        busy_o,
  output logic        exp_go_o,
  output logic [7:0]  exp_a_o,
  output logic [7:0]  exp_n_o,
  input  logic        exp_done_i,
  input  logic [15:0] exp_result_i,
  output logic        lcd_start_o,
  output logic [15:0] lcd_value_o,
  input  logic        lcd_over_i
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
`ifdef LCD_MIRROR_EN
  localparam logic [2:0] S_LCD_START = 3'd3;
  localparam logic [2:0] S_LCD_WAIT  = 3'd4;
`endif
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [7:0]    a_q, a_d, n_q, n_d;
  logic [15:0]   result_q, result_d;
  logic          err_q, err_d;
  logic [1:0]    ack_q, ack_d, valid_q, valid_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_low_q, seen_low_d;
  logic          grant;
`ifdef LCD_MIRROR_EN
  logic          lcd_start_q, lcd_start_d;
  logic [15:0]   lcd_value_q, lcd_value_d;
`endif

  function automatic logic [1:0] owner_mask(input logic who);
    return who ? 2'b10 : 2'b01;
  endfunction

  // On a tie, the requester that was not served last wins.
  assign grant = (req_i == 2'b11) ? ~last_grant_q : req_i[1];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    n_d          = n_q;
    result_d     = result_q;
    err_d        = err_q;
    ack_d        = 2'b00;
    valid_d      = 2'b00;
    go_d         = 1'b0;
    cnt_d        = cnt_q;
    seen_low_d   = seen_low_q;
`ifdef LCD_MIRROR_EN
    lcd_start_d  = 1'b0;
    lcd_value_d  = lcd_value_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = grant;
          a_d     = grant ? a1_i : a0_i;
          n_d     = grant ? n1_i : n0_i;
          ack_d   = owner_mask(grant);
          go_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d      = '0;
        seen_low_d = 1'b0;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done level left over from the previous job is ignored until it drops.
        seen_low_d = seen_low_q | ~exp_done_i;
        if (exp_done_i && seen_low_q) begin
          result_d = exp_result_i;
          err_d    = 1'b0;
`ifdef LCD_MIRROR_EN
          lcd_start_d = 1'b1;
          lcd_value_d = exp_result_i;
          state_d     = S_LCD_START;
`else
          valid_d = owner_mask(owner_q);
          state_d = S_RESP;
`endif
        end else if (cnt_q == TO_LIMIT) begin
          result_d = 16'hFFFF;
          err_d    = 1'b1;
          valid_d  = owner_mask(owner_q);
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef LCD_MIRROR_EN
      S_LCD_START: begin
        seen_low_d = 1'b0;
        state_d    = S_LCD_WAIT;
      end
      S_LCD_WAIT: begin
        seen_low_d = seen_low_q | ~lcd_over_i;
        if (lcd_over_i && seen_low_q) begin
          valid_d = owner_mask(owner_q);
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      n_q          <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      ack_q        <= '0;
      valid_q      <= '0;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      seen_low_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      n_q          <= n_d;
      result_q     <= result_d;
      err_q        <= err_d;
      ack_q        <= ack_d;
      valid_q      <= valid_d;
      go_q         <= go_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      seen_low_q   <= seen_low_d;
    end
  end

`ifdef LCD_MIRROR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_start_q <= 1'b0;
      lcd_value_q <= '0;
    end else begin
      lcd_start_q <= lcd_start_d;
      lcd_value_q <= lcd_value_d;
    end
  end

  assign lcd_start_o = lcd_start_q;
  assign lcd_value_o = lcd_value_q;
`else
  logic lcd_over_unused;
  assign lcd_over_unused = lcd_over_i;
  assign lcd_start_o     = 1'b0;
  assign lcd_value_o     = '0;
`endif

  assign ack_o    = ack_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;
  assign result_o = result_q;
  assign busy_o   = busy_q;
  assign exp_go_o = go_q;
  assign exp_a_o  = a_q;
  assign exp_n_o  = n_q;

endmodule

// File: doc/exp_job_scheduler.md
# exp_job_scheduler

Round-robin scheduler that shares one exponent FSMD (a^n engine) between two requesters. It captures a job's operands, pulses the engine's go, waits for done, and returns the 16-bit result to the requester that issued the job. It sits between the requesting logic and the exponent datapath in the top level. Optionally, it forwards each result to the LCD controller before accepting the next job.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: maximum WAIT_DONE cycles before a job is aborted.
- CW, 13: timeout counter width; must satisfy 2^CW > TIMEOUT_CYCLES.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_i  in  2  per-requester job request; a level held until ack.
- a0_i, n0_i, a1_i, n1_i  in  8 each  operands for requesters 0 and 1; stable while req is high.
- ack_o  out  2  one-cycle pulse; the operands have been taken.
- valid_o  out  2  one-cycle pulse; the result for that requester is on result_o.
- err_o  out  1  qualifies valid_o; high means the job timed out.
- result_o  out  16  result of the last completed job; held between completions.
- busy_o  out  1  high whenever state ≠ IDLE.
- exp_go_o  out  1  one-cycle start pulse to the exponent engine.
- exp_a_o, exp_n_o  out  8 each  registered operands; held stable for the whole job.
- exp_done_i  in  1  engine done level.
- exp_result_i  in  16  engine result; valid while done is high.
- lcd_start_o  out  1  one-cycle display request.
- lcd_value_o  out  16  value to display.
- lcd_over_i  in  1  LCD finished level.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, LCD_START, LCD_WAIT, RESP.
- IDLE:
  - If any req_i bit is high, grant one requester, latch its operands into exp_a_o/exp_n_o, record the owner, and go to ISSUE.
  - Arbitration:
    - If only one request is high, that requester wins.
    - If both are high, the requester not granted last wins.
    - last_grant resets to 1, so requester 0 wins the first tie.
- ISSUE (1 cycle): exp_go_o=1 and ack_o[owner]=1. Clear the timeout counter and seen_low. Go to WAIT_DONE.
- WAIT_DONE:
  - Stale-done guard: seen_low sets when exp_done_i is sampled 0.
  - When exp_done_i is high and seen_low is set, capture exp_result_i into result_o, clear err_o, and go to LCD_START (macro on) or RESP (macro off).
  - The counter increments every WAIT_DONE cycle. When it reaches TIMEOUT_CYCLES: result_o=16'hFFFF, err_o=1, go to RESP. The LCD is skipped on timeout.
- LCD_START (1 cycle): lcd_start_o=1 and lcd_value_o=result_o. Go to LCD_WAIT.
- LCD_WAIT: the same seen_low guard applies to lcd_over_i. Exit to RESP on a qualified high. There is no timeout.
- RESP (1 cycle): valid_o[owner]=1 and last_grant=owner. Go to IDLE.
- Withdrawal: a request dropped before ack is simply not granted. A request dropped after ack has no effect; the job completes and valid_o still pulses.
- Requests arriving while busy wait. Nothing is queued beyond the req_i level.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all outputs 0 except last_grant=1 (internal). exp_a_o, exp_n_o, result_o and lcd_value_o reset to 0.
- Any rst assertion returns the block to IDLE immediately, including mid-job. No valid_o or ack_o is produced for the aborted job. The engine must be reset by the same rst.
- Latency:
  - req_i high in IDLE at edge k → ack_o and exp_go_o at edge k+1.
  - Qualified done at edge d → valid_o at d+1 (macro off) or, macro on, lcd_start_o at d+1.
  - Qualified lcd_over at edge o → valid_o at o+1.
- Back-to-back: the next grant occurs in the IDLE cycle after RESP, giving a minimum 2-cycle gap between consecutive exp_go_o jobs beyond engine latency.
- ack_o and valid_o are never high for both bits at once.

## Configuration
- LCD_MIRROR_EN defined: the LCD_START and LCD_WAIT states exist, and every successful job is displayed before valid_o pulses.
- LCD_MIRROR_EN undefined: those states are removed, WAIT_DONE goes directly to RESP, lcd_start_o and lcd_value_o are tied to 0, and lcd_over_i is ignored.

## Test plan
- Single job: req0 with a=2, n=8 → ack_o=01, one exp_go_o pulse, valid_o=01, result_o=256, err_o=0.
- Tie: req0 (3,4) and req1 (5,3) raised in the same cycle → requester 0 is served first with 81, then requester 1 with 125. A repeated tie then grants requester 1 first.
- Stale done: hold exp_done_i high from the previous job through ISSUE → no capture until done has been seen low and then high again.
- Timeout: engine never asserts done, TIMEOUT_CYCLES=16 → valid_o pulses 18 cycles after ack with err_o=1 and result_o=16'hFFFF.
- Reset mid-job: assert rst during WAIT_DONE → busy_o=0 and all outputs 0 immediately; no valid_o follows. A new req0 (2,3) then returns 8.
- LCD_MIRROR_EN: job 2^8 → lcd_start_o pulses once with lcd_value_o=256, and valid_o waits until lcd_over_i goes low then high. With the macro undefined, lcd_start_o stays 0.
